// File: rtl/instructions_pkg.sv
// Shared core types: data width plus the arbiter's owner and FSM encodings.
package instructions_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_RSP
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Priority decision between fetch and load/store, with a saturating LS streak
// counter that forces a fetch grant once fetch has waited MAX_LS_STREAK grants.
module mem_arb_pick
  import instructions_pkg::*;
#(
  parameter int unsigned MAX_LS_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic ls_req,
  input  logic arb_en,
  output logic pick_if,
  output logic pick_ls
);

  localparam int unsigned SW = $clog2(MAX_LS_STREAK + 1);

  logic [SW-1:0] streak;
  logic          starved;

  always_comb begin
    starved = (streak == SW'(MAX_LS_STREAK));
    pick_ls = ls_req && !(if_req && starved);
    pick_if = if_req && !pick_ls;
  end

  // An LS grant with fetch waiting can only occur while not starved, so the
  // increment never overflows the saturation point.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (arb_en) begin
      if (pick_ls && if_req) begin
        streak <= streak + SW'(1);
      end else if (pick_ls || pick_if) begin
        streak <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction in
// flight, routing each response back to the requester that issued it.
module mem_port_arbiter
  import instructions_pkg::*;
#(
  parameter int unsigned MAX_LS_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [XLEN-1:0]   if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [XLEN/8-1:0] ls_be,
  input  logic [XLEN-1:0]   ls_addr,
  input  logic [XLEN-1:0]   ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [XLEN-1:0]   ls_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              err_stray
);

  arb_state_t state, state_nxt;
  owner_t     owner;
  logic       pick_if, pick_ls, arb_en, complete, stray;

  mem_arb_pick #(
    .MAX_LS_STREAK(MAX_LS_STREAK)
  ) u_pick (
    .clk    (clk),
    .rst    (rst),
    .if_req (if_req),
    .ls_req (ls_req),
    .arb_en (arb_en),
    .pick_if(pick_if),
    .pick_ls(pick_ls)
  );

  always_comb begin
    arb_en    = (state == ARB_IDLE) && !rst;
    if_gnt    = arb_en && pick_if;
    ls_gnt    = arb_en && pick_ls;
    state_nxt = state;
    complete  = 1'b0;
    stray     = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        stray = mem_rvalid;
        if (if_gnt || ls_gnt) state_nxt = ARB_REQ;
      end
      ARB_REQ: begin
        if (mem_gnt) begin
          complete  = mem_rvalid;
          state_nxt = mem_rvalid ? ARB_IDLE : ARB_RSP;
        end else begin
          stray = mem_rvalid;
        end
      end
      ARB_RSP: begin
        if (mem_rvalid) begin
          complete  = 1'b1;
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
    complete  = complete && !rst;
    stray     = stray && !rst;
    mem_req   = (state == ARB_REQ);
    if_rvalid = complete && (owner == OWN_IF);
    ls_rvalid = complete && (owner == OWN_LS);
    if_rdata  = mem_rdata;
    ls_rdata  = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      owner     <= OWN_LS;
      err_stray <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (stray) err_stray <= 1'b1;
      if (if_gnt) begin
        owner     <= OWN_IF;
        mem_we    <= 1'b0;
        mem_be    <= '1;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
      end else if (ls_gnt) begin
        owner     <= OWN_LS;
        mem_we    <= ls_we;
        mem_be    <= ls_be;
        mem_addr  <= ls_addr;
        mem_wdata <= ls_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed transactions push expected
// grants, memory requests and responses; a negedge monitor pops and compares.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [3:0]  ls_be;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, err_stray;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.MAX_LS_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .err_stray(err_stray)
  );

  always #5 clk = ~clk;

  typedef struct { logic own_ls; logic [31:0] data; } rsp_t;
  typedef struct { logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; } mreq_t;

  logic  exp_gnt[$];
  rsp_t  exp_rsp[$];
  mreq_t exp_mem[$];

  int unsigned n_vec = 0, n_bad = 0, cyc = 0;
  int unsigned last_if_rsp_cyc = 0, last_ls_rsp_cyc = 0;
  logic        resp_en = 1'b0;
  int unsigned gnt_wait = 0, rsp_lat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] data_for(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic mreq_t mk(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    mreq_t m;
    m.we = we; m.be = be; m.addr = a; m.wdata = wd;
    return m;
  endfunction

  function automatic rsp_t mr(input logic own_ls, input logic [31:0] d);
    rsp_t r;
    r.own_ls = own_ls; r.data = d;
    return r;
  endfunction

  // Monitor: compares whatever the DUT presents against the queue heads.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_gnt || ls_gnt) begin
        chk("gnt_onehot", {31'd0, if_gnt && ls_gnt}, 32'd0);
        if (exp_gnt.size() == 0) chk("gnt_unexpected", 32'd1, 32'd0);
        else chk("gnt_owner_is_ls", {31'd0, ls_gnt}, {31'd0, exp_gnt.pop_front()});
      end
      if (if_rvalid || ls_rvalid) begin
        rsp_t r;
        chk("rvalid_onehot", {31'd0, if_rvalid && ls_rvalid}, 32'd0);
        if (if_rvalid) last_if_rsp_cyc = cyc;
        if (ls_rvalid) last_ls_rsp_cyc = cyc;
        if (exp_rsp.size() == 0) chk("rvalid_unexpected", 32'd1, 32'd0);
        else begin
          r = exp_rsp.pop_front();
          chk("rsp_owner_is_ls", {31'd0, ls_rvalid}, {31'd0, r.own_ls});
          chk("rsp_rdata", ls_rvalid ? ls_rdata : if_rdata, r.data);
        end
      end
      if (mem_req) begin
        if (exp_mem.size() == 0) chk("mem_req_unexpected", 32'd1, 32'd0);
        else begin
          chk("mem_we", {31'd0, mem_we}, {31'd0, exp_mem[0].we});
          chk("mem_be", {28'd0, mem_be}, {28'd0, exp_mem[0].be});
          chk("mem_addr", mem_addr, exp_mem[0].addr);
          chk("mem_wdata", mem_wdata, exp_mem[0].wdata);
          if (mem_gnt) void'(exp_mem.pop_front());
        end
      end
    end
  end

  // Memory responder: grant after gnt_wait cycles, respond rsp_lat cycles later.
  initial begin
    int unsigned wcnt = 0, pend = 0;
    logic [31:0] rsp_data = '0;
    forever begin
      step();
      if (resp_en) begin
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin mem_rvalid = 1'b1; mem_rdata = rsp_data; end
        end else if (mem_req) begin
          if (wcnt < gnt_wait) wcnt++;
          else begin
            wcnt = 0;
            mem_gnt = 1'b1;
            rsp_data = data_for(mem_addr);
            if (rsp_lat == 0) begin mem_rvalid = 1'b1; mem_rdata = rsp_data; end
            else pend = rsp_lat;
          end
        end
      end
    end
  end

  task automatic if_op(input logic [31:0] a, output int unsigned gc);
    logic got = 1'b0;
    if_req = 1'b1; if_addr = a; gc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (if_gnt) begin got = 1'b1; gc = cyc; break; end
    end
    if (!got) chk("if_gnt_timeout", 32'd1, 32'd0);
    step();
    if_req = 1'b0;
  endtask

  task automatic ls_op(input logic we, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] wd, output int unsigned gc);
    logic got = 1'b0;
    ls_req = 1'b1; ls_we = we; ls_be = be; ls_addr = a; ls_wdata = wd; gc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ls_gnt) begin got = 1'b1; gc = cyc; break; end
    end
    if (!got) chk("ls_gnt_timeout", 32'd1, 32'd0);
    step();
    ls_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_rsp.size() == 0) break;
      @(negedge clk);
    end
    if (exp_rsp.size() != 0) chk("drain_timeout", 32'd1, 32'd0);
    step();
  endtask

  initial begin
    int unsigned g, g2, c0;
    rst = 1'b1; if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h0; ls_we = 1'b0;
    ls_be = 4'h0; ls_addr = 32'h0; ls_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_err_stray", {31'd0, err_stray}, 32'd0);
    chk("rst_gnts", {30'd0, if_gnt, ls_gnt}, 32'd0);
    chk("rst_rvalids", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
    step();
    rst = 1'b0; if_req = 1'b0; ls_req = 1'b0; resp_en = 1'b1;

    // LS load, gnt at N+1, data at N+3
    gnt_wait = 0; rsp_lat = 2;
    exp_gnt.push_back(1'b1);
    exp_mem.push_back(mk(1'b0, 4'hF, 32'h100, 32'h0));
    exp_rsp.push_back(mr(1'b1, 32'hDEADBEEF));
    ls_op(1'b0, 4'hF, 32'h100, 32'h0, g);
    @(negedge clk);
    chk("load_mem_req_n1", {31'd0, mem_req}, 32'd1);
    drain();
    chk("load_rsp_latency", last_ls_rsp_cyc - g, 32'd3);

    // Both requesting, zero-wait memory: LS x4, IF, LS x4, IF
    gnt_wait = 0; rsp_lat = 0;
    for (int k = 0; k < 10; k++) begin
      logic is_if;
      logic [31:0] a;
      is_if = (k == 4) || (k == 9);
      a = is_if ? (32'h1000 + ((k == 9) ? 32'd4 : 32'd0))
                : (32'h200 + 32'(4 * ((k < 4) ? k : k - 1)));
      exp_gnt.push_back(!is_if);
      exp_mem.push_back(mk(1'b0, 4'hF, a, 32'h0));
      exp_rsp.push_back(mr(!is_if, data_for(a)));
    end
    fork
      begin
        int unsigned gi;
        for (int k = 0; k < 2; k++) if_op(32'h1000 + 32'(4 * k), gi);
      end
      begin
        int unsigned gl;
        for (int k = 0; k < 8; k++) ls_op(1'b0, 4'hF, 32'h200 + 32'(4 * k), 32'h0, gl);
      end
    join
    drain();

    // Store held across 3 wait cycles, ack one cycle after gnt
    gnt_wait = 3; rsp_lat = 1;
    exp_gnt.push_back(1'b1);
    exp_mem.push_back(mk(1'b1, 4'b0011, 32'h500, 32'h12345678));
    exp_rsp.push_back(mr(1'b1, data_for(32'h500)));
    ls_op(1'b1, 4'b0011, 32'h500, 32'h12345678, g);
    drain();
    chk("store_ack_latency", last_ls_rsp_cyc - g, 32'd5);

    // Same-cycle gnt+rvalid on IF read, then immediate LS grant
    gnt_wait = 0; rsp_lat = 0;
    exp_gnt.push_back(1'b0);
    exp_mem.push_back(mk(1'b0, 4'hF, 32'h40, 32'h0));
    exp_rsp.push_back(mr(1'b0, data_for(32'h40)));
    exp_gnt.push_back(1'b1);
    exp_mem.push_back(mk(1'b0, 4'hF, 32'h600, 32'h0));
    exp_rsp.push_back(mr(1'b1, data_for(32'h600)));
    if_op(32'h40, g);
    ls_op(1'b0, 4'hF, 32'h600, 32'h0, g2);
    drain();
    chk("fast_if_rsp_latency", last_if_rsp_cyc - g, 32'd1);
    chk("fast_regrant_spacing", g2 - g, 32'd2);

    // Reset while in RSP, late response is stray
    resp_en = 1'b0;
    exp_gnt.push_back(1'b1);
    exp_mem.push_back(mk(1'b0, 4'hF, 32'h300, 32'h0));
    ls_op(1'b0, 4'hF, 32'h300, 32'h0, g);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_mem_req", {31'd0, mem_req}, 32'd0);
    step(); step();
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD0BAD;
    @(negedge clk);
    chk("late_rsp_no_rvalid", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
    step();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("late_rsp_err_stray", {31'd0, err_stray}, 32'd1);
    chk("late_rsp_mem_req", {31'd0, mem_req}, 32'd0);

    // Stray in IDLE: sticky, FSM stays idle
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("stray_cleared_by_rst", {31'd0, err_stray}, 32'd0);
    step();
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_stray_sticky", {31'd0, err_stray}, 32'd1);
      chk("idle_stray_no_req", {31'd0, mem_req}, 32'd0);
    end
    step();
    resp_en = 1'b1; gnt_wait = 0; rsp_lat = 0;
    exp_gnt.push_back(1'b1);
    exp_mem.push_back(mk(1'b0, 4'hF, 32'h700, 32'h0));
    exp_rsp.push_back(mr(1'b1, data_for(32'h700)));
    c0 = cyc;
    ls_op(1'b0, 4'hF, 32'h700, 32'h0, g);
    chk("idle_after_stray_gnt_now", g, c0);
    drain();
    @(negedge clk);
    chk("stray_still_set", {31'd0, err_stray}, 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("stray_cleared_final", {31'd0, err_stray}, 32'd0);

    chk("gnt_queue_empty", exp_gnt.size(), 32'd0);
    chk("mem_queue_empty", exp_mem.size(), 32'd0);
    chk("rsp_queue_empty", exp_rsp.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares one unified memory port between the core's instruction-fetch requester and its load/store requester. It sits between the core pipeline and the memory subsystem. It allows one outstanding transaction at a time and routes each response back to the requester that owns it. Load/store has priority, and a streak counter bounds how long fetch can be starved.

## Interface
- XLEN, 32, data/address width
- MAX_LS_STREAK, 4, consecutive LS grants allowed while IF is waiting (≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  XLEN  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  XLEN  fetch data
- ls_req  in  1  load/store request; held with fields until ls_gnt
- ls_we  in  1  1 = store
- ls_be  in  XLEN/8  byte enables
- ls_addr, ls_wdata  in  XLEN  address, store data
- ls_gnt, ls_rvalid  out  1  accepted / response valid (load data or store ack)
- ls_rdata  out  XLEN  load data
- mem_req  out  1  request to memory; held until mem_gnt
- mem_we, mem_be, mem_addr, mem_wdata  out  1/XLEN/8/XLEN/XLEN  registered request fields
- mem_gnt  in  1  memory accepted request
- mem_rvalid  in  1  memory response valid
- mem_rdata  in  XLEN  memory read data
- err_stray  out  1  sticky: mem_rvalid arrived with no outstanding transaction

## Operation
- FSM states:
  - IDLE: arbitrate. If a winner exists, assert its gnt combinationally, latch its fields and owner, and go to REQ.
  - REQ: mem_req=1. On mem_gnt go to RSP. If mem_rvalid arrives in the same cycle as mem_gnt, complete immediately and go to IDLE.
  - RSP: wait for mem_rvalid, then go to IDLE.
- Arbitration:
  - LS wins by default.
  - IF wins when only if_req is set, or when both are set and streak == MAX_LS_STREAK.
- Streak counter (saturating at MAX_LS_STREAK):
  - increments on an LS grant while if_req=1;
  - clears on an IF grant or on an LS grant with if_req=0.
- Response routing: mem_rvalid/mem_rdata are forwarded combinationally to the owner's rvalid/rdata. The non-owner's rvalid stays 0, and both rdata outputs carry mem_rdata.
- mem_be is driven all-ones for IF transactions; mem_we=0 for IF.
- mem_rvalid in IDLE is ignored, sets err_stray, and does not change state.
- mem_rvalid in REQ without mem_gnt is treated as stray in the same way.

## Timing
- Reset values: FSM=IDLE, streak=0, err_stray=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, owner=LS. Both gnt and both rvalid outputs are 0.
- Request to mem_req: gnt in cycle N (IDLE), mem_req=1 from cycle N+1.
- mem_req and its fields are stable from N+1 until the cycle mem_gnt=1 inclusive, then drop next cycle.
- Response: owner rvalid in the same cycle as mem_rvalid.
- Minimum transaction spacing: 3 cycles (IDLE→REQ→RSP). With same-cycle gnt+rvalid it is 2 cycles.
- Requester may drop req the cycle after its gnt. The arbiter does not sample it again until the next IDLE.
- Reset mid-transaction: return to IDLE next edge and drop the in-flight owner. A late mem_rvalid after reset is stray.
- No gnt is issued in REQ or RSP, even if requests are pending.

## Structure
- Add owner_t {OWN_IF, OWN_LS} and arb_state_t {ARB_IDLE, ARB_REQ, ARB_RSP} to instructions_pkg; XLEN comes from the same package.
- One natural sub-module: mem_arb_pick, holding the streak counter plus the priority decision (outputs pick_if, pick_ls). The FSM and request registers stay in mem_port_arbiter.

## Test plan
- LS load only: ls_req, addr 0x100; mem_gnt at N+1, mem_rvalid=1 at N+3 with data 0xDEADBEEF. Expected: ls_gnt at N, mem_addr=0x100 at N+1, ls_rvalid with ls_rdata=0xDEADBEEF at N+3, if_rvalid=0 throughout.
- Both requesting continuously, MAX_LS_STREAK=4, zero-wait memory. Expected grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF, with streak clearing after each IF grant.
- Store with ls_be=4'b0011, wdata 0x12345678. Expected: mem_we=1, mem_be=4'b0011, mem_wdata=0x12345678 held across 3 wait cycles of mem_gnt=0; ls_rvalid on the ack.
- Same-cycle mem_gnt+mem_rvalid on an IF read of 0x40. Expected: if_rvalid in that cycle, FSM back in IDLE the next cycle, and a new grant possible that cycle.
- rst=1 while in RSP, then mem_rvalid two cycles after reset release. Expected: no rvalid to either requester, err_stray=1, mem_req=0.
- mem_rvalid pulsed while IDLE with no request. Expected: err_stray stays 1 until rst, and FSM stays IDLE.
